// File: rtl/keypad_time_encoder_if.sv
// Keypad-side signal bundle for keypad_time_encoder: key inputs, entry controls,
// the BCD time digits and the accept/reject pulses.
interface keypad_time_encoder_if;
  logic [9:0] Keypad;
  logic       Clear;
  logic       LoadEn;
  logic [3:0] Minutes;
  logic [3:0] TenSec;
  logic [3:0] Sec;
  logic       DataValid;
  logic       KeyAccept;
  logic       KeyReject;

  modport master (
    output Keypad, Clear, LoadEn,
    input  Minutes, TenSec, Sec, DataValid, KeyAccept, KeyReject
  );

  modport slave (
    input  Keypad, Clear, LoadEn,
    output Minutes, TenSec, Sec, DataValid, KeyAccept, KeyReject
  );
endinterface

// File: rtl/keypad_time_encoder.sv
// Debounced keypad-to-BCD time entry; keys shift in at Sec toward Minutes.
// Optional idle auto-clear is enabled with the KEYPAD_TIMEOUT_EN macro.
module keypad_time_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input logic                  clk,
  input logic                  rst,
  keypad_time_encoder_if.slave kp
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE} state_e;

  localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;
  logic [3:0] min_q, min_d, ten_q, ten_d, sec_q, sec_d;
  logic       acc_q, acc_d, rej_q, rej_d;
  logic [3:0] hits, key_code;
  logic       key_none, key_single, resolve, accept, data_valid, timeout;

  always_comb begin
    hits     = '0;
    key_code = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (kp.Keypad[i]) begin
        hits     = hits + 4'd1;
        key_code = 4'(i);
      end
    end
    key_none   = (hits == 4'd0);
    key_single = (hits == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // cnt counts stable key samples in DEBOUNCE and stable release samples in WAIT_RELEASE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    resolve = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_single) begin
          code_d = key_code;
          if (DbLast == 8'd1) begin
            resolve = 1'b1;
            state_d = WAIT_RELEASE;
            cnt_d   = '0;
          end else begin
            state_d = DEBOUNCE;
            cnt_d   = 8'd1;
          end
        end else if (!key_none) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (key_single && key_code == code_q) begin
          if (cnt_q + 8'd1 == DbLast) begin
            resolve = 1'b1;
            state_d = WAIT_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (!key_none) begin
          cnt_d = '0;
        end else if (cnt_q + 8'd1 == DbLast) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    accept = resolve && !kp.Clear && kp.LoadEn && (sec_q <= 4'd5);
    acc_d  = accept;
    rej_d  = resolve && !accept;
    min_d  = min_q;
    ten_d  = ten_q;
    sec_d  = sec_q;
    if (kp.Clear || timeout) begin
      min_d = '0;
      ten_d = '0;
      sec_d = '0;
    end else if (accept) begin
      min_d = ten_q;
      ten_d = sec_q;
      sec_d = key_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      ten_q <= '0;
      sec_q <= '0;
      acc_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      min_q <= min_d;
      ten_q <= ten_d;
      sec_q <= sec_d;
      acc_q <= acc_d;
      rej_q <= rej_d;
    end
  end

  assign data_valid = |{min_q, ten_q, sec_q};

`ifdef KEYPAD_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (data_valid && state_q == IDLE && kp.LoadEn && key_none) begin
      if (idle_q + 32'd1 == 32'(TIMEOUT_CYCLES)) timeout = 1'b1;
      else idle_d = idle_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign kp.Minutes   = min_q;
  assign kp.TenSec    = ten_q;
  assign kp.Sec       = sec_q;
  assign kp.DataValid = data_valid;
  assign kp.KeyAccept = acc_q;
  assign kp.KeyReject = rej_q;

endmodule

// File: tb/tb_keypad_time_encoder.sv
// Directed self-checking bench for keypad_time_encoder (default build, DEBOUNCE_CYCLES = 4).
module tb_keypad_time_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_n = 0;
  int   rej_n = 0;
  int   both_n = 0;
  int   acc0, rej0;

  keypad_time_encoder_if kif ();

  keypad_time_encoder #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kif.KeyAccept === 1'b1) acc_n++;
    if (kif.KeyReject === 1'b1) rej_n++;
    if (kif.KeyAccept === 1'b1 && kif.KeyReject === 1'b1) both_n++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] digits();
    return {20'd0, kif.Minutes, kif.TenSec, kif.Sec};
  endfunction

  // hold one key for `hold` samples, then release for 5 samples
  task automatic press(input int key, input int hold);
    kif.Keypad = 10'd1 << key;
    step(hold);
    kif.Keypad = '0;
    step(5);
  endtask

  initial begin
    kif.Keypad = '0;
    kif.Clear  = 1'b0;
    kif.LoadEn = 1'b1;
    step(2);
    rst = 1'b0;
    chk("reset_digits", digits(), 32'h000);
    chk("reset_valid", {31'd0, kif.DataValid}, 32'd0);
    chk("reset_accept", {31'd0, kif.KeyAccept}, 32'd0);
    chk("reset_reject", {31'd0, kif.KeyReject}, 32'd0);

    // key 1 with exact pulse timing: resolves on the 4th sampling edge
    acc0 = acc_n;
    kif.Keypad = 10'd1 << 1;
    step(3);
    chk("k1_no_early_accept", {31'd0, kif.KeyAccept}, 32'd0);
    step(1);
    chk("k1_accept_pulse", {31'd0, kif.KeyAccept}, 32'd1);
    chk("k1_digits", digits(), 32'h001);
    step(1);
    chk("k1_pulse_one_cycle", {31'd0, kif.KeyAccept}, 32'd0);
    step(1);
    kif.Keypad = '0;
    step(5);
    chk("k1_one_accept", acc_n - acc0, 32'd1);

    press(3, 6);
    chk("k3_digits", digits(), 32'h013);
    press(0, 6);
    chk("k0_digits", digits(), 32'h130);
    chk("three_accepts", acc_n - acc0, 32'd3);
    chk("valid_after_entry", {31'd0, kif.DataValid}, 32'd1);

    // key 5 bounce 1,1,0,1,1,1,1 then hold 50
    acc0 = acc_n;
    rej0 = rej_n;
    kif.Keypad = 10'd1 << 5; step(2);
    kif.Keypad = '0;         step(1);
    kif.Keypad = 10'd1 << 5; step(3);
    chk("bounce_no_pulse", acc_n - acc0, 32'd0);
    step(1);
    chk("bounce_accept", {31'd0, kif.KeyAccept}, 32'd1);
    chk("bounce_digits", digits(), 32'h305);
    step(50);
    kif.Keypad = '0;
    step(5);
    chk("hold_no_repeat", acc_n - acc0, 32'd1);
    chk("hold_no_reject", rej_n - rej0, 32'd0);

    // too-short press (3 samples) is ignored
    acc0 = acc_n;
    press(8, 3);
    chk("short_press_none", (acc_n - acc0) + (rej_n - rej0), 32'd0);

    // clear, then 0/0/7 and key 2 rejected because Sec > 5
    kif.Clear = 1'b1; step(1); kif.Clear = 1'b0;
    chk("clear_digits", digits(), 32'h000);
    chk("clear_valid", {31'd0, kif.DataValid}, 32'd0);
    press(7, 6);
    chk("d7_digits", digits(), 32'h007);
    acc0 = acc_n;
    rej0 = rej_n;
    press(2, 6);
    chk("sec_gt5_reject", rej_n - rej0, 32'd1);
    chk("sec_gt5_no_accept", acc_n - acc0, 32'd0);
    chk("sec_gt5_digits", digits(), 32'h007);

    // keys 3 and 4 together: no pulse at all
    rej0 = rej_n;
    kif.Keypad = 10'b00_0001_1000;
    step(6);
    kif.Keypad = '0;
    step(5);
    chk("multi_no_pulse", (acc_n - acc0) + (rej_n - rej0), 32'd0);
    chk("multi_digits", digits(), 32'h007);

    // LoadEn low rejects key 9
    kif.Clear = 1'b1; step(1); kif.Clear = 1'b0;
    press(1, 6);
    press(3, 6);
    press(0, 6);
    chk("reload_digits", digits(), 32'h130);
    acc0 = acc_n;
    rej0 = rej_n;
    kif.LoadEn = 1'b0;
    press(9, 6);
    kif.LoadEn = 1'b1;
    chk("loaden_reject", rej_n - rej0, 32'd1);
    chk("loaden_no_accept", acc_n - acc0, 32'd0);
    chk("loaden_digits", digits(), 32'h130);

    // Clear on the resolving edge of a valid key wins and turns it into a reject
    acc0 = acc_n;
    rej0 = rej_n;
    kif.Keypad = 10'd1 << 2;
    step(3);
    kif.Clear = 1'b1;
    step(1);
    kif.Clear = 1'b0;
    chk("clr_edge_reject", {31'd0, kif.KeyReject}, 32'd1);
    chk("clr_edge_no_accept", {31'd0, kif.KeyAccept}, 32'd0);
    chk("clr_edge_digits", digits(), 32'h000);
    step(2);
    kif.Keypad = '0;
    step(5);
    chk("clr_edge_counts", (acc_n - acc0) * 16 + (rej_n - rej0), 32'd1);

    // reset during debounce discards the partial count
    kif.Keypad = 10'd1 << 6;
    step(2);
    rst = 1'b1; step(1); rst = 1'b0;
    acc0 = acc_n;
    step(3);
    chk("rst_mid_no_accept", acc_n - acc0, 32'd0);
    step(1);
    chk("rst_mid_accept", {31'd0, kif.KeyAccept}, 32'd1);
    chk("rst_mid_digits", digits(), 32'h006);
    kif.Keypad = '0;
    step(5);

    chk("never_both", both_n, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
